// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: op codes, rounding modes,
// fflags bit positions and the canonical quiet NaN.
package fpu_pkg;

    localparam logic [4:0] OP_FADD   = 5'b00000;
    localparam logic [4:0] OP_FSUB   = 5'b00001;
    localparam logic [4:0] OP_FMUL   = 5'b00010;
    localparam logic [4:0] OP_FDIV   = 5'b00011;
    localparam logic [4:0] OP_FSQRT  = 5'b01011;
    localparam logic [4:0] OP_SGNJ   = 5'b00100;
    localparam logic [4:0] OP_MINMAX = 5'b00101;
    localparam logic [4:0] OP_CVT_W  = 5'b11000;
    localparam logic [4:0] OP_CVT_S  = 5'b11010;
    localparam logic [4:0] OP_CMP    = 5'b10100;
    localparam logic [4:0] OP_CLASS  = 5'b11100;
    localparam logic [4:0] OP_MV     = 5'b11110;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    localparam logic [31:0] CANON_NAN     = 32'h7FC0_0000;
    localparam logic [4:0]  FFLAGS_NV_ONLY = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Only these ops consume a rounding mode; the rest use funct3 as a sub-op select.
    function automatic logic is_rounding_op(input logic [4:0] op);
        return op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_CVT_W, OP_CVT_S};
    endfunction

    function automatic logic rm_is_legal(input logic [2:0] rm);
        return rm <= RM_RMM;
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the dynamic rounding mode against frm and flags reserved modes
// for ops that actually round.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic [2:0] req_rm_i,
    input  logic [2:0] frm_i,
    output logic [2:0] rm_o,
    output logic       illegal_o
);

    always_comb begin
        rm_o      = req_rm_i;
        illegal_o = 1'b0;
        if (is_rounding_op(op_i)) begin
            if (req_rm_i == RM_DYN) begin
                rm_o = frm_i;
            end
            illegal_o = !rm_is_legal(rm_o);
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU arithmetic handshake: one instruction in flight,
// registered result/flags to writeback, sticky fflags. Optional BUSY timeout via FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_rs2_lsb,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  frm,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rounding_mode,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_invalid,
    input  logic        fpu_inexact,
    input  logic        fpu_div_by_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [4:0]  rsp_fflags,
    output logic        rsp_illegal,
    input  logic        fflags_clr,
    output logic [4:0]  fflags_acc,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload holds while valid && !ready.

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("fpu_issue_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    issue_state_e state_q;
    logic         fpu_start_q;
    logic [4:0]   fpu_op_q;
    logic [2:0]   fpu_rm_q;
    logic [31:0]  fpu_a_q;
    logic [31:0]  fpu_b_q;
    logic         fpu_rs2_q;
    logic         rsp_valid_q;
    logic [31:0]  rsp_data_q;
    logic [4:0]   rsp_rd_q;
    logic [4:0]   rsp_fflags_q;
    logic         rsp_illegal_q;
    logic [4:0]   fflags_acc_q;
    logic [4:0]   fflags_acc_d;

    logic [2:0]   rm_res;
    logic         rm_illegal;
    logic [4:0]   done_flags;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] busy_cnt_q;
`endif

    fpu_rm_resolve u_rm_resolve (
        .op_i      (req_op),
        .req_rm_i  (req_rm),
        .frm_i     (frm),
        .rm_o      (rm_res),
        .illegal_o (rm_illegal)
    );

    always_comb begin
        done_flags        = '0;
        done_flags[FF_NV] = fpu_invalid;
        done_flags[FF_DZ] = fpu_div_by_zero;
        done_flags[FF_OF] = fpu_overflow;
        done_flags[FF_UF] = fpu_underflow;
        done_flags[FF_NX] = fpu_inexact;
    end

    // Clear first, then OR in the retiring response so same-cycle flags survive a clear.
    always_comb begin
        fflags_acc_d = fflags_clr ? 5'b00000 : fflags_acc_q;
        if (rsp_valid_q && rsp_ready) begin
            fflags_acc_d = fflags_acc_d | rsp_fflags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fpu_start_q   <= 1'b0;
            fpu_op_q      <= '0;
            fpu_rm_q      <= '0;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_rs2_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rd_q      <= '0;
            rsp_fflags_q  <= '0;
            rsp_illegal_q <= 1'b0;
            fflags_acc_q  <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            busy_cnt_q    <= '0;
`endif
        end else begin
            fflags_acc_q <= fflags_acc_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        fpu_op_q  <= req_op;
                        fpu_rm_q  <= rm_res;
                        fpu_a_q   <= req_a;
                        fpu_b_q   <= req_b;
                        fpu_rs2_q <= req_rs2_lsb;
                        rsp_rd_q  <= req_rd;
                        if (rm_illegal) begin
                            // Reserved rounding mode: answer directly, never start the unit.
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_illegal_q <= 1'b1;
                            rsp_data_q    <= '0;
                            rsp_fflags_q  <= '0;
                        end else begin
                            state_q     <= ST_BUSY;
                            fpu_start_q <= 1'b1;
`ifdef FPU_ISSUE_TIMEOUT_EN
                            busy_cnt_q  <= '0;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (fpu_done) begin
                        state_q       <= ST_RESP;
                        fpu_start_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= fpu_result;
                        rsp_fflags_q  <= done_flags;
                        rsp_illegal_q <= 1'b0;
                    end
`ifdef FPU_ISSUE_TIMEOUT_EN
                    else if (busy_cnt_q == TO_LAST) begin
                        state_q       <= ST_RESP;
                        fpu_start_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= CANON_NAN;
                        rsp_fflags_q  <= FFLAGS_NV_ONLY;
                        rsp_illegal_q <= 1'b0;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready         = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign fpu_start         = fpu_start_q;
    assign fpu_op            = fpu_op_q;
    assign fpu_rounding_mode = fpu_rm_q;
    assign fpu_a             = fpu_a_q;
    assign fpu_b             = fpu_b_q;
    assign fpu_rs2_lsb       = fpu_rs2_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_rd            = rsp_rd_q;
    assign rsp_fflags        = rsp_fflags_q;
    assign rsp_illegal       = rsp_illegal_q;
    assign fflags_acc        = fflags_acc_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: a behavioural FPU responder, a response
// monitor against an expected queue, and a sticky-flag model.
module tb_fpu_issue_ctrl;

  localparam int TO = 8;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [2:0]  req_rm = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_rs2_lsb = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [2:0]  frm = '0;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rounding_mode;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_result = '0;
  logic        fpu_done = 1'b0;
  logic        fpu_overflow = 1'b0;
  logic        fpu_underflow = 1'b0;
  logic        fpu_invalid = 1'b0;
  logic        fpu_inexact = 1'b0;
  logic        fpu_div_by_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [4:0]  rsp_fflags;
  logic        rsp_illegal;
  logic        fflags_clr = 1'b0;
  logic [4:0]  fflags_acc;
  logic        busy;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd), .frm(frm),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rounding_mode(fpu_rounding_mode),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_invalid(fpu_invalid),
    .fpu_inexact(fpu_inexact), .fpu_div_by_zero(fpu_div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
    .fflags_clr(fflags_clr), .fflags_acc(fflags_acc), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  fl;
    logic        ill;
  } rsp_t;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic        rs2;
    int          lat;
    logic [31:0] res;
    logic [4:0]  fl;
    int          starts;
  } iss_t;

  rsp_t exp_q[$];
  iss_t iss_q[$];
  logic [4:0] acc_m = '0;
  int n_chk = 0, n_fail = 0;
  int n_exp = 0, n_rsp = 0;
  int first_start_cyc = 0, first_rsp_cyc = 0;
  int rdy_mode = 1;     // 0 manual, 1 always ready, 2 random
  bit clr_rand = 1'b0;
  bit noise = 1'b0;

  logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b00100,
                           5'b00101, 5'b11000, 5'b11010, 5'b10100, 5'b11100, 5'b11110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic bit is_round(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b11000, 5'b11010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] fr,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] res, input logic [4:0] fl, output int acc_cyc);
    logic [2:0] rrm;
    bit ill, tmo;
    rsp_t e;
    iss_t s;
    logic [4:0] rd;
    logic rs2;
    int budget;
    rd  = 5'($urandom);
    rs2 = 1'($urandom);
    rrm = (is_round(op) && rm == 3'b111) ? fr : rm;
    ill = is_round(op) && (rrm == 3'b101 || rrm == 3'b110 || rrm == 3'b111);
    tmo = TIMEOUT_ON && (lat == 0 || lat > TO);
    e.rd = rd;
    if (ill) begin
      e.data = 32'h0; e.fl = 5'b00000; e.ill = 1'b1;
    end else if (tmo) begin
      e.data = 32'h7FC0_0000; e.fl = 5'b10000; e.ill = 1'b0;
    end else begin
      e.data = res; e.fl = fl; e.ill = 1'b0;
    end
    s.op = op; s.rm = rrm; s.a = a; s.b = b; s.rs2 = rs2; s.lat = lat;
    s.res = res; s.fl = fl; s.starts = tmo ? TO : lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
    req_rs2_lsb = rs2; req_rd = rd; frm = fr;
    acc_cyc = -1;
    budget = 0;
    while (acc_cyc < 0 && budget <= 500) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc_n;
        exp_q.push_back(e);
        if (!ill) iss_q.push_back(s);
        n_exp++;
      end else begin
        budget++;
      end
    end
    if (acc_cyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL req_accept: got no req_ready expected accept within 500 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 5'($urandom); req_rm = 3'($urandom); req_a = $urandom; req_b = $urandom;
    req_rd = 5'($urandom); frm = 3'($urandom);
  endtask

  task automatic wait_rsp();
    int b = 0;
    while (n_rsp != n_exp && b <= 3000) begin
      @(negedge clk);
      b++;
    end
    if (n_rsp != n_exp) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_wait: got %0d responses expected %0d", n_rsp, n_exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_fpu_start"}, 32'(fpu_start), 32'h0);
    chk({tag, "_fpu_op"}, 32'(fpu_op), 32'h0);
    chk({tag, "_fpu_rm"}, 32'(fpu_rounding_mode), 32'h0);
    chk({tag, "_fpu_a"}, fpu_a, 32'h0);
    chk({tag, "_fpu_b"}, fpu_b, 32'h0);
    chk({tag, "_fpu_rs2"}, 32'(fpu_rs2_lsb), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_rsp_rd"}, 32'(rsp_rd), 32'h0);
    chk({tag, "_rsp_fflags"}, 32'(rsp_fflags), 32'h0);
    chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'h0);
    chk({tag, "_fflags_acc"}, 32'(fflags_acc), 32'h0);
  endtask

  // ---------------- background drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) rsp_ready = 1'b1;
    else if (rdy_mode == 2) rsp_ready = ($urandom_range(0, 2) != 0);
    if (clr_rand) fflags_clr = ($urandom_range(0, 5) == 0);
  end

  // Behavioural FPU: raises done on the lat-th start cycle with the planned result.
  initial begin : fpu_model
    iss_t ci;
    bit have_iss = 1'b0;
    int fcyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fcyc = 0; have_iss = 1'b0; fpu_done = 1'b0;
      end else if (fpu_start) begin
        fcyc++;
        if (fcyc == 1) begin
          first_start_cyc = cyc_n;
          if (iss_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL start_unexpected: got fpu_start=1 expected 0 (no legal request pending)");
          end else begin
            ci = iss_q.pop_front();
            have_iss = 1'b1;
          end
        end
        if (have_iss) begin
          chk("fpu_op", 32'(fpu_op), 32'(ci.op));
          chk("fpu_rm", 32'(fpu_rounding_mode), 32'(ci.rm));
          chk("fpu_a", fpu_a, ci.a);
          chk("fpu_b", fpu_b, ci.b);
          chk("fpu_rs2", 32'(fpu_rs2_lsb), 32'(ci.rs2));
        end
        if (have_iss && ci.lat != 0 && fcyc == ci.lat) begin
          fpu_done = 1'b1;
          fpu_result = ci.res;
          {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact} = ci.fl;
        end else begin
          fpu_done = 1'b0;
          fpu_result = $urandom;
          {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact} = 5'($urandom);
        end
      end else begin
        if (fcyc > 0 && have_iss) chk("start_cycles", 32'(fcyc), 32'(ci.starts));
        fcyc = 0;
        have_iss = 1'b0;
        fpu_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        fpu_result = $urandom;
        {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact} = 5'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    rsp_t cur;
    bit have_cur = 1'b0;
    logic [4:0] nxt;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur = 1'b0;
      end else begin
        chk("fflags_acc", 32'(fflags_acc), 32'(acc_m));
        nxt = fflags_clr ? 5'b00000 : acc_m;
        if (rsp_valid) begin
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1'b1;
              first_rsp_cyc = cyc_n;
            end
          end
          if (have_cur) begin
            chk("rsp_data", rsp_data, cur.data);
            chk("rsp_rd", 32'(rsp_rd), 32'(cur.rd));
            chk("rsp_fflags", 32'(rsp_fflags), 32'(cur.fl));
            chk("rsp_illegal", 32'(rsp_illegal), 32'(cur.ill));
            chk("resp_req_ready", 32'(req_ready), 32'h0);
            chk("resp_fpu_start", 32'(fpu_start), 32'h0);
            if (rsp_ready) begin
              nxt = nxt | cur.fl;
              have_cur = 1'b0;
              n_rsp++;
            end
          end
        end
        acc_m = nxt;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int ac;
    int wb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // FADD 1.0 + 2.0, single-cycle unit
    send_req(5'b00000, 3'b000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 1, 32'h4040_0000, 5'b00000, ac);
    wait_rsp();
    chk("fadd_start_latency", 32'(first_start_cyc - ac), 32'd1);
    chk("fadd_rsp_latency", 32'(first_rsp_cyc - ac), 32'd2);
    @(negedge clk);
    chk("fadd_acc", 32'(fflags_acc), 32'h0);

    // FMUL dynamic rm resolves to frm, then a reserved frm makes it illegal
    send_req(5'b00010, 3'b111, 3'b001, $urandom, $urandom, 3, $urandom, 5'b00001, ac);
    wait_rsp();
    send_req(5'b00010, 3'b111, 3'b101, $urandom, $urandom, 3, $urandom, 5'b00000, ac);
    wait_rsp();
    chk("illegal_rsp_latency", 32'(first_rsp_cyc - ac), 32'd1);

    // FEQ: funct3 passes through even with a reserved frm
    send_req(5'b10100, 3'b010, 3'b111, $urandom, $urandom, 1, 32'h1, 5'b00000, ac);
    wait_rsp();

    // FDIV 1.0 / 0.0 with a long latency and divide-by-zero
    reset = 1'b0;
    @(posedge clk); #1;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    send_req(5'b00011, 3'b000, 3'b000, 32'h3F80_0000, 32'h0, 12, 32'h7F80_0000, 5'b01000, ac);
    wait_rsp();
    @(negedge clk);
`ifndef FPU_ISSUE_TIMEOUT_EN
    chk("fdiv_acc", 32'(fflags_acc), 32'h08);
`endif

    // Backpressure, then a clear coinciding with an NX response
    rdy_mode = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_req(5'b00000, 3'b000, 3'b000, $urandom, $urandom, 1, $urandom, 5'b00001, ac);
    wb = 0;
    while (!rsp_valid && wb < 100) begin
      @(negedge clk);
      wb++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    fflags_clr = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("clr_with_nx_acc", 32'(fflags_acc), 32'h01);
    rdy_mode = 1;

`ifdef FPU_ISSUE_TIMEOUT_EN
    // Unit never answers: controller must give up with a canonical NaN
    send_req(5'b00000, 3'b000, 3'b000, $urandom, $urandom, 0, $urandom, 5'b00000, ac);
    wait_rsp();
`endif

    // Randomized traffic with backpressure, random clears and done noise when idle
    rdy_mode = 2;
    clr_rand = 1'b1;
    noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int lat;
      lat = TIMEOUT_ON ? $urandom_range(0, TO + 3) : $urandom_range(1, 16);
      send_req(ops[$urandom_range(0, 11)], 3'($urandom), 3'($urandom), $urandom, $urandom,
               lat, $urandom, 5'($urandom), ac);
    end
    wait_rsp();
    clr_rand = 1'b0;
    noise = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;

    // Reset while an FDIV is in flight
    send_req(5'b00011, 3'b000, 3'b000, $urandom, $urandom, 0, $urandom, 5'b00000, ac);
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    acc_m = '0;
    n_exp = n_rsp;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_busy_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Recovery after reset
    send_req(5'b00001, 3'b011, 3'b000, $urandom, $urandom, 2, $urandom, 5'b00100, ac);
    wait_rsp();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
